// File: rtl/data_mem_mmio_if.sv
// CPU data-memory bus plus the host-side output FIFO handshake.
// The CPU or bench is the master; data_mem_mmio is the slave.
interface data_mem_mmio_if #(
  parameter int SIZE = 32
);
  logic            WE;
  logic [SIZE-1:0] A;
  logic [SIZE-1:0] WD;
  logic [SIZE-1:0] RD;
  logic            OutValid;
  logic [SIZE-1:0] OutData;
  logic            OutReady;

  modport master (
    output WE, A, WD, OutReady,
    input  RD, OutValid, OutData
  );

  modport slave (
    input  WE, A, WD, OutReady,
    output RD, OutValid, OutData
  );
endinterface

// File: rtl/data_mem_mmio.sv
// Word RAM plus a small MMIO page: a free-running cycle counter, an output FIFO
// drained by the host, and a saturating counter of pushes dropped while full.
module data_mem_mmio #(
  parameter int SIZE       = 32,
  parameter int DEPTH      = 64,
  parameter int FIFO_DEPTH = 4
) (
  input logic            CLK,
  input logic            Reset,
  data_mem_mmio_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [SIZE-1:0] ADDR_CYCLE  = SIZE'(32'h0000_1000);
  localparam logic [SIZE-1:0] ADDR_OUT    = SIZE'(32'h0000_1004);
  localparam logic [SIZE-1:0] ADDR_STATUS = SIZE'(32'h0000_1008);
  localparam logic [SIZE-1:0] ADDR_DROPS  = SIZE'(32'h0000_100C);

  logic [SIZE-1:0] ram [DEPTH];
  logic [SIZE-1:0] fifo [FIFO_DEPTH];

  logic [SIZE-1:0] cycle_q;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [7:0]      drops_q;

  logic [SIZE-1:0] a_word;
  logic            ram_sel;
  logic            sel_cycle;
  logic            sel_out;
  logic            sel_status;
  logic            sel_drops;
  logic            full;
  logic            empty;
  logic            pop;
  logic            push_req;
  logic            push;
  logic            drop;
  logic [SIZE-1:0] status;
  logic            unused_a_lsb;

  // Byte offset within a word is ignored everywhere.
  assign a_word       = {bus.A[SIZE-1:2], 2'b00};
  assign unused_a_lsb = ^bus.A[1:0];

  assign ram_sel    = (bus.A[SIZE-1:AW+2] == '0);
  assign sel_cycle  = (a_word == ADDR_CYCLE);
  assign sel_out    = (a_word == ADDR_OUT);
  assign sel_status = (a_word == ADDR_STATUS);
  assign sel_drops  = (a_word == ADDR_DROPS);

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign pop   = bus.OutValid && bus.OutReady;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign push_req = bus.WE && sel_out;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  assign bus.OutValid = !empty;
  assign bus.OutData  = fifo[rd_ptr_q];

  always_comb begin
    status      = '0;
    status[7:4] = 4'(count_q);
    status[1]   = empty;
    status[0]   = full;
  end

  always_comb begin
    bus.RD = '0;
    if (ram_sel)         bus.RD = ram[bus.A[AW+1:2]];
    else if (sel_cycle)  bus.RD = cycle_q;
    else if (sel_status) bus.RD = status;
    else if (sel_drops)  bus.RD = SIZE'(drops_q);
  end

  always_ff @(posedge CLK) begin
    if (bus.WE && ram_sel) ram[bus.A[AW+1:2]] <= bus.WD;
  end

  always_ff @(posedge CLK) begin
    if (push) fifo[wr_ptr_q] <= bus.WD;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) cycle_q <= '0;
    else        cycle_q <= cycle_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= PW'(wr_ptr_q + 1'b1);
      if (pop)  rd_ptr_q <= PW'(rd_ptr_q + 1'b1);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      drops_q <= '0;
    end else if (bus.WE && sel_drops) begin
      drops_q <= '0;
    end else if (drop && (drops_q != 8'hFF)) begin
      drops_q <= drops_q + 1'b1;
    end
  end
endmodule
